// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential fetch, execute redirects, buffered redirects.
// Drives D/E flushes and tracks redirect count and misaligned targets.
module pc_redirect_unit #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallf,
  input  logic             imem_ready,
  input  logic [1:0]       pcsrce,
  input  logic [XLEN-1:0]  pctargete,
  input  logic [XLEN-1:0]  aluresulte,
  output logic [XLEN-1:0]  pcf,
  output logic [XLEN-1:0]  pcplus4f,
  output logic             flushd,
  output logic             flushe,
  output logic             redirect_pending,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic            redir_now;
  logic [XLEN-1:0] tgt;
  logic            pend_v;
  logic [XLEN-1:0] pend_tgt;
  logic            cnt_sat;

  // Decode redirect code; JALR target has bit 0 cleared, code 11 is inert.
  always_comb begin
    redir_now = 1'b0;
    tgt = pctargete;
    unique case (pcsrce)
      2'b01: redir_now = 1'b1;
      2'b10: begin
        redir_now = 1'b1;
        tgt = aluresulte & ~ONE;
      end
      default: redir_now = 1'b0;
    endcase
  end

  assign pcplus4f = pcf + FOUR;
  assign flushe = redir_now;
  assign flushd = redir_now | pend_v;
  assign redirect_pending = pend_v;
  assign cnt_sat = &redirect_count;

  // PC and pending-redirect update; a redirect always beats stallf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf <= RESET_PC;
      pend_v <= 1'b0;
      pend_tgt <= '0;
    end else begin
      unique case (1'b1)
        redir_now && imem_ready: begin
          pcf <= tgt;
          pend_v <= 1'b0;
        end
        redir_now && !imem_ready: begin
          pend_v <= 1'b1;
          pend_tgt <= tgt;
        end
        !redir_now && pend_v && imem_ready: begin
          pcf <= pend_tgt;
          pend_v <= 1'b0;
        end
        !redir_now && !pend_v && imem_ready && !stallf:
          pcf <= pcplus4f;
        default: ;
      endcase
    end
  end

  // Sticky misalign flag and saturating redirect counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
      redirect_count <= '0;
    end else begin
      if (redir_now && tgt[1])
        misalign_err <= 1'b1;
      if (redir_now && !cnt_sat)
        redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit.
// Each scenario task drives stimulus and checks inline.
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst;
  logic        stallf;
  logic        imem_ready;
  logic [1:0]  pcsrce;
  logic [31:0] pctargete;
  logic [31:0] aluresulte;
  logic [31:0] pcf;
  logic [31:0] pcplus4f;
  logic        flushd;
  logic        flushe;
  logic        redirect_pending;
  logic        misalign_err;
  logic [15:0] redirect_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt;

  pc_redirect_unit dut (
    .clk(clk),
    .rst(rst),
    .stallf(stallf),
    .imem_ready(imem_ready),
    .pcsrce(pcsrce),
    .pctargete(pctargete),
    .aluresulte(aluresulte),
    .pcf(pcf),
    .pcplus4f(pcplus4f),
    .flushd(flushd),
    .flushe(flushe),
    .redirect_pending(redirect_pending),
    .misalign_err(misalign_err),
    .redirect_count(redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stallf = 1'b0;
    imem_ready = 1'b1;
    pcsrce = 2'b00;
    pctargete = '0;
    aluresulte = '0;
    #3;
    checks++; if (pcf !== 32'h0) begin failures++; $display("FAIL rst_pcf got=%h exp=%h", pcf, 32'h0); end
    checks++; if (pcplus4f !== 32'h4) begin failures++; $display("FAIL rst_pcplus4 got=%h exp=%h", pcplus4f, 32'h4); end
    checks++; if ({flushd, flushe} !== 2'b00) begin failures++; $display("FAIL rst_flush got=%b exp=00", {flushd, flushe}); end
    checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", redirect_pending); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b exp=0", misalign_err); end
    checks++; if (redirect_count !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", redirect_count); end
    tick();
    rst = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pcf !== 32'(4 * i)) begin failures++; $display("FAIL run_pcf got=%h exp=%h", pcf, 32'(4 * i)); end
      checks++; if ({flushd, flushe} !== 2'b00) begin failures++; $display("FAIL run_flush got=%b exp=00", {flushd, flushe}); end
    end
  endtask

  task automatic test_stall_redirect();
    repeat (13) tick();
    checks++; if (pcf !== 32'h40) begin failures++; $display("FAIL pre_stall_pcf got=%h exp=%h", pcf, 32'h40); end
    stallf = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pcf !== 32'h40) begin failures++; $display("FAIL stall_pcf got=%h exp=%h", pcf, 32'h40); end
    end
    pcsrce = 2'b01;
    pctargete = 32'h100;
    #1;
    checks++; if ({flushd, flushe} !== 2'b11) begin failures++; $display("FAIL redir_flush got=%b exp=11", {flushd, flushe}); end
    tick();
    pcsrce = 2'b00;
    stallf = 1'b0;
    #1;
    checks++; if (pcf !== 32'h100) begin failures++; $display("FAIL redir_pcf got=%h exp=%h", pcf, 32'h100); end
    checks++; if ({flushd, flushe} !== 2'b00) begin failures++; $display("FAIL redir_flush_off got=%b exp=00", {flushd, flushe}); end
    checks++; if (redirect_count !== 16'd1) begin failures++; $display("FAIL redir_cnt got=%h exp=%h", redirect_count, 16'd1); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL redir_mis got=%b exp=0", misalign_err); end
  endtask

  task automatic test_jalr();
    pcsrce = 2'b10;
    aluresulte = 32'h203;
    pctargete = 32'h999;
    tick();
    pcsrce = 2'b00;
    #1;
    checks++; if (pcf !== 32'h202) begin failures++; $display("FAIL jalr_pcf got=%h exp=%h", pcf, 32'h202); end
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL jalr_mis got=%b exp=1", misalign_err); end
    checks++; if (redirect_count !== 16'd2) begin failures++; $display("FAIL jalr_cnt got=%h exp=%h", redirect_count, 16'd2); end
    tick();
    tick();
    checks++; if (pcf !== 32'h20a) begin failures++; $display("FAIL jalr_seq got=%h exp=%h", pcf, 32'h20a); end
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL jalr_sticky got=%b exp=1", misalign_err); end
  endtask

  task automatic test_buffered();
    imem_ready = 1'b0;
    pcsrce = 2'b01;
    pctargete = 32'h80;
    #1;
    checks++; if ({flushd, flushe} !== 2'b11) begin failures++; $display("FAIL buf_flush0 got=%b exp=11", {flushd, flushe}); end
    tick();
    pcsrce = 2'b00;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL buf_pend got=%b exp=1", redirect_pending); end
      checks++; if ({flushd, flushe} !== 2'b10) begin failures++; $display("FAIL buf_flush got=%b exp=10", {flushd, flushe}); end
      checks++; if (pcf !== 32'h20a) begin failures++; $display("FAIL buf_hold got=%h exp=%h", pcf, 32'h20a); end
      tick();
    end
    imem_ready = 1'b1;
    stallf = 1'b1;
    #1;
    checks++; if ({flushd, flushe} !== 2'b10) begin failures++; $display("FAIL buf_flush_rdy got=%b exp=10", {flushd, flushe}); end
    tick();
    stallf = 1'b0;
    #1;
    checks++; if (pcf !== 32'h80) begin failures++; $display("FAIL buf_pcf got=%h exp=%h", pcf, 32'h80); end
    checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL buf_pend_clr got=%b exp=0", redirect_pending); end
    checks++; if (flushd !== 1'b0) begin failures++; $display("FAIL buf_flushd_clr got=%b exp=0", flushd); end
    checks++; if (redirect_count !== 16'd3) begin failures++; $display("FAIL buf_cnt got=%h exp=%h", redirect_count, 16'd3); end
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b0;
    pcsrce = 2'b01;
    pctargete = 32'h300;
    tick();
    pcsrce = 2'b00;
    #1;
    checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL ar_pend_pre got=%b exp=1", redirect_pending); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pcf !== 32'h0) begin failures++; $display("FAIL ar_pcf got=%h exp=%h", pcf, 32'h0); end
    checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL ar_pend got=%b exp=0", redirect_pending); end
    checks++; if (redirect_count !== 16'h0) begin failures++; $display("FAIL ar_cnt got=%h exp=0", redirect_count); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL ar_mis got=%b exp=0", misalign_err); end
    tick();
    rst = 1'b1;
    imem_ready = 1'b1;
    #1;
  endtask

  task automatic test_wrap_and_code11();
    pcsrce = 2'b01;
    pctargete = 32'hFFFF_FFFC;
    tick();
    pcsrce = 2'b11;
    pctargete = 32'h0000_0502;
    aluresulte = 32'h0000_0702;
    #1;
    checks++; if (pcf !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", pcf, 32'hFFFF_FFFC); end
    checks++; if (pcplus4f !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=%h", pcplus4f, 32'h0); end
    checks++; if ({flushd, flushe} !== 2'b00) begin failures++; $display("FAIL c11_flush got=%b exp=00", {flushd, flushe}); end
    tick();
    checks++; if (pcf !== 32'h0) begin failures++; $display("FAIL wrap_pcf got=%h exp=%h", pcf, 32'h0); end
    tick();
    pcsrce = 2'b00;
    #1;
    checks++; if (pcf !== 32'h4) begin failures++; $display("FAIL c11_seq got=%h exp=%h", pcf, 32'h4); end
    checks++; if (redirect_count !== 16'd1) begin failures++; $display("FAIL c11_cnt got=%h exp=%h", redirect_count, 16'd1); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL c11_mis got=%b exp=0", misalign_err); end
  endtask

  task automatic test_saturation();
    exp_cnt = 16'd1;
    pcsrce = 2'b01;
    pctargete = 32'h1000;
    repeat (65534) begin
      tick();
      exp_cnt = exp_cnt + 16'd1;
    end
    checks++; if (redirect_count !== exp_cnt) begin failures++; $display("FAIL sat_full got=%h exp=%h", redirect_count, exp_cnt); end
    tick();
    checks++; if (redirect_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=%h", redirect_count, 16'hFFFF); end
    pcsrce = 2'b00;
    #1;
    checks++; if (pcf !== 32'h1000) begin failures++; $display("FAIL sat_pcf got=%h exp=%h", pcf, 32'h1000); end
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_jalr();
    test_buffered();
    test_async_reset();
    test_wrap_and_code11();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-stage program-counter owner for the pipelined RISC-V core. It consumes the 2-bit `pcsrce` redirect code produced by the execute-stage jump/branch resolver and generates the fetch PC. It also raises the flush signals that squash wrong-path instructions in D and E. Redirects that arrive while instruction memory is not ready are buffered until fetch can accept them, so no control transfer is lost. The block sits between the execute-stage resolver, the hazard unit and instruction memory.

## Interface
- `XLEN`, 32, datapath/PC width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, 16, width of the redirect counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `stallf`  in  1  hazard-unit fetch stall; holds the PC when no redirect is present.
- `imem_ready`  in  1  instruction memory can accept a new fetch address this cycle.
- `pcsrce`  in  2  redirect code from execute. 00 = sequential, 01 = PC-relative target (branch taken / JAL), 10 = register target (JALR), 11 = reserved, treated as 00.
- `pctargete`  in  XLEN  `PC_E + imm`, used for code 01.
- `aluresulte`  in  XLEN  `rs1 + imm`, used for code 10.
- `pcf`  out  XLEN  current fetch PC (register).
- `pcplus4f`  out  XLEN  `pcf + 4`, combinational, wraps modulo 2^XLEN.
- `flushd`  out  1  squash the IF/ID register this cycle.
- `flushe`  out  1  squash the ID/EX register this cycle.
- `redirect_pending`  out  1  a buffered redirect is waiting for `imem_ready`.
- `misalign_err`  out  1  sticky flag: a redirect target had `target[1] = 1`.
- `redirect_count`  out  CNT_W  number of accepted redirects, saturating.

## Operation
- `redir_now = (pcsrce == 01) | (pcsrce == 10)`.
- Target selection:
  - Code 01: `tgt = pctargete`.
  - Code 10: `tgt = {aluresulte[XLEN-1:1], 1'b0}` (JALR clears bit 0).
- State registers: `pcf`, `pend_v`, `pend_tgt`, `misalign_err`, `redirect_count`.
- Next-state rules, evaluated in priority order:
  1. `redir_now & imem_ready`: `pcf <= tgt`, `pend_v <= 0`.
  2. `redir_now & ~imem_ready`: `pend_v <= 1`, `pend_tgt <= tgt`, `pcf` holds. If a redirect is already pending, the newest one overwrites it.
  3. `pend_v & imem_ready`: `pcf <= pend_tgt`, `pend_v <= 0`. This overrides `stallf`.
  4. `pend_v & ~imem_ready`: all state holds.
  5. No redirect and nothing pending: `pcf <= pcf + 4` if `imem_ready & ~stallf`; otherwise `pcf` holds.
- Redirect priority: a redirect always overrides `stallf`, because the stalled D instruction is on the wrong path.
- `misalign_err` is set in any cycle where `redir_now` and `tgt[1] = 1`. It is cleared only by reset. The target is still used unchanged.
- `redirect_count` increments by 1 on every cycle where `redir_now` is 1, and saturates at all-ones.
- Flush outputs (combinational):
  - `flushe = redir_now`.
  - `flushd = redir_now | pend_v`.
- `redirect_pending = pend_v`.

## Timing
- Reset values: `pcf = RESET_PC`, `pend_v = 0`, `pend_tgt = 0`, `misalign_err = 0`, `redirect_count = 0`.
- Outputs during reset: `flushd = flushe = 0` while `pcsrce = 00`; `pcplus4f = RESET_PC + 4`.
- Reset asserted mid-operation immediately clears any pending redirect and returns `pcf` to `RESET_PC`, independent of the clock.
- Redirect latency:
  - With `imem_ready = 1`: `pcf` equals the target one cycle after `redir_now`.
  - With `imem_ready = 0`: `pcf` equals the target one cycle after the first cycle in which `imem_ready` is 1.
- Flush timing:
  - `flushe` is high only in the `redir_now` cycle.
  - `flushd` is high from the `redir_now` cycle through the last cycle in which `pend_v` is 1.
- Sequential wrap: `pcf = 32'hFFFF_FFFC` advances to `32'h0000_0000`.
- `pcsrce = 11`: no flush, no count, no error, normal sequential behaviour.

## Test plan
- Reset then run: release `rst` with `imem_ready = 1`, `stallf = 0`, `pcsrce = 00` for 3 cycles. Required: `pcf` = 0, 4, 8, 12; flushes stay 0.
- Stall and redirect together: with `pcf = 0x40`, hold `stallf = 1` for 2 cycles, then assert `pcsrce = 01`, `pctargete = 0x100` while `stallf = 1`. Required: `pcf` holds at 0x40 during the stall, then equals 0x100 the next cycle; `flushd = flushe = 1` for exactly 1 cycle; `redirect_count = 1`.
- JALR bit clearing: `pcsrce = 10`, `aluresulte = 0x203`. Required: `pcf = 0x202` next cycle, `misalign_err = 1` and it stays 1 afterwards.
- Buffered redirect: with `imem_ready = 0`, assert `pcsrce = 01`, `pctargete = 0x80` for 1 cycle, keep `imem_ready = 0` for 3 more cycles, then set it to 1. Required: `redirect_pending = 1` and `flushd = 1` throughout the wait; `flushe` high only in the first cycle; `pcf = 0x80` one cycle after `imem_ready` rises; `redirect_pending` then drops to 0.
- Reset during pending redirect: pull `rst` low asynchronously mid-cycle while a redirect is buffered. Required: `pcf = RESET_PC`, `redirect_pending = 0` and `redirect_count = 0` immediately, without waiting for a clock edge.
- Saturation and wrap: preload the counter to 0xFFFF with 65535 redirects, then apply one more. Required: `redirect_count` stays 0xFFFF. Separately, sequential fetch from `pcf = 0xFFFF_FFFC` gives `pcf = 0x0`.
